wb_commit_trace_buffer: RTL and testbench
=========================================

Name: wb_commit_trace_buffer

Overview:
- Sits directly downstream of the processor's write-back stage and consumes what the MEM/WB pipeline register produces.
- Captures every architecturally visible register-file write into a first-word-fall-through FIFO as a trace entry: pc, rd, data and sequence number.
- A bench or debug port drains entries with a valid/ready handshake. Verification can then check retire order against a golden model instead of polling internal register values.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2.
- SEQ_W, 16, width of the commit sequence counter.
- DROP_W, 8, width of the saturating dropped-commit counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO and counters.
- wb_rf_enable  input  1  write-back register-file write enable.
- wb_rd  input  5  write-back destination register.
- wb_data  input  32  write-back data (MEM/WB mux output).
- wb_pc  input  32  pc of the retiring instruction.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts head.
- out_pc  output  32  head entry pc.
- out_rd  output  5  head entry rd.
- out_data  output  32  head entry data.
- out_seq  output  SEQ_W  head entry sequence number.
- count  output  log2(DEPTH)+1  entries currently held.
- overflow  output  1  sticky: at least one commit dropped.
- drop_count  output  DROP_W  dropped commits, saturating.

Behaviour:
- Reset (reset=0, asynchronous): pointers, count and seq_ctr go to 0; drop_count goes to 0; overflow=0; out_valid=0. out_pc, out_rd, out_data and out_seq read 0 while empty.
- Commit qualify: commit = wb_rf_enable && (wb_rd != 0). Writes to x0 are ignored entirely: no push, and seq_ctr does not advance.
- Sequence: seq_ctr increments by 1 mod 2^SEQ_W on every qualifying commit, whether accepted or dropped. The entry stores the pre-increment value, so gaps in out_seq expose drops.
- Pop: pop = out_valid && out_ready, evaluated on the rising edge.
- Push: push_ok = commit && (!full || pop). When full, a simultaneous pop frees the slot and the push is accepted the same cycle.
- Drop: drop = commit && full && !pop.
  - overflow sets to 1 and stays set.
  - drop_count increments and saturates at 2^DROP_W-1.
- Latency: a commit sampled at edge N appears at the outputs after edge N (out_valid=1 in cycle N+1) if the FIFO was empty.
- Output mode is FWFT: the out_* fields always show the head entry. They change only on pop, or on push into an empty FIFO.
- count: count_next = count + push_ok - pop. Push and pop in the same cycle leave count unchanged. Empty means count==0; full means count==DEPTH.
- Pointers: read and write pointers wrap modulo DEPTH.
- Flush (synchronous): on an edge with flush=1, pointers, count, seq_ctr, overflow and drop_count all clear to 0. Flush overrides any simultaneous commit or pop: the commit is discarded and is not counted as a drop.
- Reset mid-operation: an asynchronous reset wipes all state. Storage contents need not be cleared, but out_valid=0 guarantees stale data is never presented.
- out_ready while empty: no effect.
- No combinational path exists from wb_* inputs to any output.
  - out_valid comes from count.
  - out_* come from storage at the read pointer.

Decomposition:
- Shared package (riscv_trace_pkg):
  - XLEN=32 and REGADDR_W=5.
  - A trace-entry packed struct {pc, rd, data, seq}, with SEQ_W taken from the block parameter.
- Natural sub-module: trace_fifo, a generic FWFT synchronous FIFO with DEPTH/WIDTH parameters, push/pop, full/empty and count.
- The top level holds commit qualification, seq_ctr, drop logic and flush sequencing.

Test Plan:
- Basic commit: after reset release, commit rd=5, data=0x0000000A, pc=0x00000008, with out_ready=0 → next cycle out_valid=1, out_rd=5, out_data=10, out_pc=8, out_seq=0, count=1.
- x0 filter: commit rd=0 data=0xFFFFFFFF, then rd=3 data=7 → only one entry, out_rd=3 and out_seq=0; the x0 write does not consume a sequence number.
- Fill/overflow: out_ready=0 and 18 consecutive commits with DEPTH=16 → count=16, overflow=1, drop_count=2. Draining yields seq 0..15, and the next accepted commit carries seq 18.
- Full with simultaneous push/pop: FIFO full, out_ready=1 and a commit on the same edge → count stays 16, drop_count unchanged, new entry is last in drain order.
- Flush: FIFO holding 4 entries with overflow=1, flush=1 plus a commit on the same edge → count=0, out_valid=0, overflow=0, drop_count=0. The next commit gets seq 0.
- Asynchronous reset: assert reset=0 mid-cycle while out_valid=1 → out_valid, count and overflow drop to 0 immediately without waiting for a clk edge. After release, a commit gets seq 0.

Source files
------------

// File: rtl/riscv_trace_pkg.sv
// riscv_trace_pkg: shared widths and commit qualification for the write-back trace buffer
package riscv_trace_pkg;
  localparam int XLEN = 32;
  localparam int REGADDR_W = 5;
  // A write to x0 is architecturally invisible, so it never becomes a trace entry.
  function automatic logic is_commit(input logic en, input logic [REGADDR_W-1:0] rd);
    return en && (rd != '0);
  endfunction
endpackage

// File: rtl/wb_commit_trace_buffer_fifo.sv
// trace_fifo: generic first-word-fall-through synchronous FIFO with count and synchronous clear
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty_o = count_q == '0;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  // Next pointers and occupancy; clear beats any concurrent push or pop.
  always_comb begin
    wptr_d = clear_i ? '0 : wptr_q + AW'(do_push);
    rptr_d = clear_i ? '0 : rptr_q + AW'(do_pop);
    count_d = clear_i ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // Pointer and count state, wiped asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  // Storage is not reset; an empty FIFO masks whatever stale data it holds.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/wb_commit_trace_buffer.sv
// wb_commit_trace_buffer: records every visible register-file write-back as an ordered trace entry
module wb_commit_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wb_rf_enable,
  input  logic [REGADDR_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic [XLEN-1:0]        wb_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [REGADDR_W-1:0]   out_rd,
  output logic [XLEN-1:0]        out_data,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);
  // The entry layout depends on SEQ_W, so it lives here rather than in the package.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [REGADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
    logic [SEQ_W-1:0]     seq;
  } trace_entry_t;
  trace_entry_t wentry, rentry;
  logic commit, pop, full, empty, drop;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  assign commit = is_commit(wb_rf_enable, wb_rd);
  assign pop = !empty && out_ready;
  assign drop = commit && full && !pop && !flush;
  assign wentry = '{pc: wb_pc, rd: wb_rd, data: wb_data, seq: seq_q};
  trace_fifo #(.DEPTH(DEPTH), .WIDTH($bits(trace_entry_t))) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear_i(flush),
    .push_i (commit),
    .pop_i  (pop),
    .wdata_i(wentry),
    .rdata_o(rentry),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  assign out_valid = !empty;
  assign out_pc = rentry.pc;
  assign out_rd = rentry.rd;
  assign out_data = rentry.data;
  assign out_seq = rentry.seq;
  assign overflow = overflow_q;
  assign drop_count = drop_q;
  // Sequence advances on every qualified commit, dropped or not; drop tracking saturates.
  always_comb begin
    seq_d = flush ? '0 : seq_q + SEQ_W'(commit);
    overflow_d = flush ? 1'b0 : overflow_q || drop;
    drop_d = flush ? '0 : (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end
  // Counter state with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q <= '0;
      overflow_q <= 1'b0;
      drop_q <= '0;
    end else begin
      seq_q <= seq_d;
      overflow_q <= overflow_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_wb_commit_trace_buffer.sv
// tb_wb_commit_trace_buffer: directed self-checking bench for the write-back trace buffer
module tb_wb_commit_trace_buffer;
  logic clk = 0, reset = 0, flush = 0, wb_rf_enable = 0, out_ready = 0;
  logic [4:0] wb_rd = 0;
  logic [31:0] wb_data = 0, wb_pc = 0;
  logic out_valid, overflow;
  logic [31:0] out_pc, out_data;
  logic [4:0] out_rd;
  logic [15:0] out_seq;
  logic [4:0] count;
  logic [7:0] drop_count;
  int checks = 0, failures = 0;

  wb_commit_trace_buffer #(.DEPTH(16), .SEQ_W(16), .DROP_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wb_rf_enable(wb_rf_enable),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data),
    .out_seq(out_seq), .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
    wb_rf_enable = 1; wb_rd = rd; wb_data = data; wb_pc = pc;
    cyc();
    wb_rf_enable = 0;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_valid", 64'(out_valid), 0);
    reset = 1;
    cyc();
    chk("rst_count", 64'(count), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_pc", 64'(out_pc), 0);
    chk("rst_seq", 64'(out_seq), 0);
    // basic commit
    commit(5, 32'h0000000A, 32'h00000008);
    chk("basic_valid", 64'(out_valid), 1);
    chk("basic_rd", 64'(out_rd), 5);
    chk("basic_data", 64'(out_data), 10);
    chk("basic_pc", 64'(out_pc), 8);
    chk("basic_seq", 64'(out_seq), 0);
    chk("basic_count", 64'(count), 1);
    out_ready = 1; cyc(); out_ready = 0;
    chk("basic_drain_valid", 64'(out_valid), 0);
    chk("basic_drain_data", 64'(out_data), 0);
    // x0 filter after flush
    flush = 1; cyc(); flush = 0;
    commit(0, 32'hFFFFFFFF, 32'h10);
    chk("x0_count", 64'(count), 0);
    chk("x0_valid", 64'(out_valid), 0);
    commit(3, 32'h7, 32'h14);
    chk("x0_next_count", 64'(count), 1);
    chk("x0_next_rd", 64'(out_rd), 3);
    chk("x0_next_data", 64'(out_data), 7);
    chk("x0_next_seq", 64'(out_seq), 0);
    out_ready = 1; cyc(); out_ready = 0;
    // fill and overflow: 18 commits, 2 dropped
    flush = 1; cyc(); flush = 0;
    for (int i = 0; i < 18; i++) commit(5'(i % 31 + 1), 32'(i), 32'(i * 4));
    chk("fill_count", 64'(count), 16);
    chk("fill_overflow", 64'(overflow), 1);
    chk("fill_drop", 64'(drop_count), 2);
    chk("fill_head_data", 64'(out_data), 0);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", 64'(out_seq), 64'(i));
      cyc();
    end
    out_ready = 0;
    chk("drain_empty", 64'(count), 0);
    commit(7, 32'h77, 32'h100);
    chk("post_drop_seq", 64'(out_seq), 18);
    out_ready = 1; cyc(); out_ready = 0;
    // full with simultaneous push and pop: seq 19..34 fill, new entry gets 35
    for (int i = 0; i < 16; i++) commit(5'(i % 31 + 1), 32'(100 + i), 32'(i * 4));
    chk("full2_count", 64'(count), 16);
    out_ready = 1;
    commit(9, 32'hABCD, 32'h300);
    chk("pushpop_count", 64'(count), 16);
    chk("pushpop_drop", 64'(drop_count), 2);
    chk("pushpop_head_seq", 64'(out_seq), 20);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("pushpop_last_data", 64'(out_data), 64'hABCD);
        chk("pushpop_last_seq", 64'(out_seq), 35);
      end
      cyc();
    end
    out_ready = 0;
    chk("pushpop_empty", 64'(out_valid), 0);
    // flush with 4 entries held and overflow sticky
    for (int i = 0; i < 4; i++) commit(5'(i + 1), 32'(i), 32'(i));
    chk("preflush_count", 64'(count), 4);
    chk("preflush_overflow", 64'(overflow), 1);
    flush = 1; wb_rf_enable = 1; wb_rd = 2; wb_data = 32'h55;
    cyc();
    flush = 0; wb_rf_enable = 0;
    chk("flush_count", 64'(count), 0);
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_overflow", 64'(overflow), 0);
    chk("flush_drop", 64'(drop_count), 0);
    commit(4, 32'h44, 32'h200);
    chk("postflush_seq", 64'(out_seq), 0);
    // overfill to set overflow: 1 held + 16 commits -> 1 drop
    for (int i = 0; i < 16; i++) commit(5'(i % 31 + 1), 32'(i), 32'(i));
    chk("prerst_overflow", 64'(overflow), 1);
    chk("prerst_drop", 64'(drop_count), 1);
    // asynchronous reset mid-cycle
    #2 reset = 0;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_count", 64'(count), 0);
    chk("arst_overflow", 64'(overflow), 0);
    chk("arst_drop", 64'(drop_count), 0);
    cyc();
    reset = 1;
    commit(6, 32'h66, 32'h400);
    chk("postrst_seq", 64'(out_seq), 0);
    chk("postrst_data", 64'(out_data), 64'h66);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
